// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: icache-side enqueue and ID-side dequeue.
// The queue attaches as slave; the fetch/decode side (or a bench) attaches as master.
interface fetch_queue_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned META_W = 34
);
    logic              enq_valid;
    logic              enq_ready;
    logic [XLEN-1:0]   enq_pc;
    logic [31:0]       enq_instr;
    logic [META_W-1:0] enq_meta;
    logic              deq_valid;
    logic              deq_ready;
    logic [XLEN-1:0]   deq_pc;
    logic [31:0]       deq_instr;
    logic [META_W-1:0] deq_meta;

    modport slave (
        input  enq_valid, enq_pc, enq_instr, enq_meta, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_instr, deq_meta
    );

    modport master (
        output enq_valid, enq_pc, enq_instr, enq_meta, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_instr, deq_meta
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between icache responses and the IF/ID register.
// Circular buffer with explicit count, one-cycle flush and optional empty bypass.
module fetch_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned META_W       = 34,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    fetch_queue_if.slave                 q,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic [31:0]                  full_stall_cycles
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];
    logic [META_W-1:0] meta_mem  [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic empty;
    logic full;
    logic bypass_on;
    logic enq_fire;
    logic deq_fire;
    logic pass_through;
    logic wr;
    logic rd;

    always_comb begin
        empty     = (count == '0);
        full      = (count == CNT_W'(DEPTH));
        bypass_on = (BYPASS != 0) && empty;

        q.enq_ready = !full;
        if (bypass_on) begin
            q.deq_valid = q.enq_valid && !flush;
            q.deq_pc    = q.enq_pc;
            q.deq_instr = q.enq_instr;
            q.deq_meta  = q.enq_meta;
        end else begin
            q.deq_valid = !empty && !flush;
            q.deq_pc    = pc_mem[head];
            q.deq_instr = instr_mem[head];
            q.deq_meta  = meta_mem[head];
        end

        enq_fire     = q.enq_valid && !full && !flush;
        deq_fire     = q.deq_valid && q.deq_ready;
        // An entry consumed straight through the bypass never touches storage.
        pass_through = bypass_on && enq_fire && q.deq_ready;
        wr           = enq_fire && !pass_through;
        rd           = deq_fire && !pass_through;

        almost_full  = (32'(count) >= AFULL_THRESH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr) tail <= tail + PTR_W'(1);
            if (rd) head <= head + PTR_W'(1);
            if (wr && !rd)      count <= count + CNT_W'(1);
            else if (!wr && rd) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_stall_cycles <= '0;
        end else if (q.enq_valid && full && !flush && (full_stall_cycles != '1)) begin
            full_stall_cycles <= full_stall_cycles + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[tail]    <= q.enq_pc;
            instr_mem[tail] <= q.enq_instr;
            meta_mem[tail]  <= q.enq_meta;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model checked every cycle.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFULL = 3;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [2:0]  count;
    logic        almost_full;
    logic [31:0] full_stall_cycles;

    int checks   = 0;
    int failures = 0;

    fetch_queue_if #(.XLEN(32), .META_W(34)) bus ();

    fetch_queue #(
        .DEPTH(DEPTH), .XLEN(32), .META_W(34), .BYPASS(1), .AFULL_THRESH(AFULL)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .q(bus),
        .count(count), .almost_full(almost_full), .full_stall_cycles(full_stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [33:0] meta;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mstall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_valid();
        if (flush) return 1'b0;
        if (mq.size() > 0) return 1'b1;
        return bus.enq_valid;
    endfunction

    // Reference model: occupancy is the queue length, head is mq[0].
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mstall = 32'd0;
        end else if (flush) begin
            mq.delete();
        end else begin
            logic take, accept;
            ent_t e;
            take   = exp_valid() && bus.deq_ready;
            accept = bus.enq_valid && (mq.size() < DEPTH);
            if (bus.enq_valid && mq.size() == DEPTH && mstall != 32'hFFFF_FFFF)
                mstall = mstall + 32'd1;
            if (!(mq.size() == 0 && take)) begin
                if (take) void'(mq.pop_front());
                if (accept) begin
                    e.pc = bus.enq_pc; e.instr = bus.enq_instr; e.meta = bus.enq_meta;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            mstall = 32'd0;
        end
        chk("m_deq_valid", {63'd0, bus.deq_valid}, {63'd0, exp_valid()});
        chk("m_enq_ready", {63'd0, bus.enq_ready}, {63'd0, mq.size() < DEPTH});
        chk("m_count", {61'd0, count}, 64'(mq.size()));
        chk("m_almost_full", {63'd0, almost_full}, {63'd0, mq.size() >= AFULL});
        chk("m_stall", {32'd0, full_stall_cycles}, {32'd0, mstall});
        if (exp_valid()) begin
            if (mq.size() > 0) begin
                chk("m_deq_pc", {32'd0, bus.deq_pc}, {32'd0, mq[0].pc});
                chk("m_deq_instr", {32'd0, bus.deq_instr}, {32'd0, mq[0].instr});
                chk("m_deq_meta", {30'd0, bus.deq_meta}, {30'd0, mq[0].meta});
            end else begin
                chk("m_byp_pc", {32'd0, bus.deq_pc}, {32'd0, bus.enq_pc});
                chk("m_byp_instr", {32'd0, bus.deq_instr}, {32'd0, bus.enq_instr});
                chk("m_byp_meta", {30'd0, bus.deq_meta}, {30'd0, bus.enq_meta});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        bus.enq_valid = v;
        bus.enq_pc    = pc;
        bus.enq_instr = instr;
        bus.enq_meta  = {2'b10, ~pc};
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.deq_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        repeat (3) step();
        rst = 1'b0;
        #2;
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_deq_valid", {63'd0, bus.deq_valid}, 64'd0);
        chk("rst_enq_ready", {63'd0, bus.enq_ready}, 64'd1);
        chk("rst_stall", {32'd0, full_stall_cycles}, 64'd0);
        step();

        // Bypass on an empty queue
        drive(1'b1, 32'h60, 32'h0000_0013);
        bus.deq_ready = 1'b1;
        #2;
        chk("byp_valid", {63'd0, bus.deq_valid}, 64'd1);
        chk("byp_pc", {32'd0, bus.deq_pc}, 64'h60);
        chk("byp_instr", {32'd0, bus.deq_instr}, 64'h13);
        step();
        drive(1'b0, 32'd0, 32'd0);
        #2;
        chk("byp_count", {61'd0, count}, 64'd0);
        step();

        // Fill to full, stall three cycles, then drain in order
        bus.deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i));
            step();
        end
        drive(1'b1, 32'h10, 32'hA000_0004);
        #2;
        chk("full_count", {61'd0, count}, 64'd4);
        chk("full_enq_ready", {63'd0, bus.enq_ready}, 64'd0);
        chk("full_afull", {63'd0, almost_full}, 64'd1);
        repeat (3) step();
        drive(1'b0, 32'd0, 32'd0);
        #2;
        chk("full_stall3", {32'd0, full_stall_cycles}, 64'd3);
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_pc", {32'd0, bus.deq_pc}, 64'(4 * i));
            chk("drain_instr", {32'd0, bus.deq_instr}, 64'(32'hA000_0000 + 32'(i)));
            step();
        end
        #2;
        chk("drain_count", {61'd0, count}, 64'd0);
        step();

        // Interleaved enq/deq from count=2 across pointer wrap
        bus.deq_ready = 1'b0;
        drive(1'b1, 32'h100, 32'hB0); step();
        drive(1'b1, 32'h104, 32'hB1); step();
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h108 + 32'(4 * i), 32'hB2 + 32'(i));
            #2;
            chk("wrap_pc", {32'd0, bus.deq_pc}, 64'(32'h100 + 32'(4 * i)));
            chk("wrap_count", {61'd0, count}, 64'd2);
            step();
        end
        bus.deq_ready = 1'b0;
        drive(1'b1, 32'h120, 32'hB8);
        step();

        // Flush with three entries while enqueue and dequeue are requested
        flush = 1'b1;
        bus.deq_ready = 1'b1;
        drive(1'b1, 32'h300, 32'hC0);
        #2;
        chk("flush_deq_valid", {63'd0, bus.deq_valid}, 64'd0);
        chk("flush_enq_ready", {63'd0, bus.enq_ready}, 64'd1);
        chk("flush_count_pre", {61'd0, count}, 64'd3);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        #2;
        chk("post_flush_count", {61'd0, count}, 64'd0);
        chk("post_flush_valid", {63'd0, bus.deq_valid}, 64'd0);
        step();
        bus.deq_ready = 1'b0;
        drive(1'b1, 32'h200, 32'hD0);
        step();
        drive(1'b0, 32'd0, 32'd0);
        #2;
        chk("post_flush_enq_count", {61'd0, count}, 64'd1);
        chk("post_flush_enq_pc", {32'd0, bus.deq_pc}, 64'h200);
        step();
        drive(1'b1, 32'h204, 32'hD1);
        step();
        drive(1'b0, 32'd0, 32'd0);

        // Asynchronous reset in the middle of a cycle
        #2;
        chk("pre_rst_count", {61'd0, count}, 64'd2);
        rst = 1'b1;
        #1;
        chk("async_rst_count", {61'd0, count}, 64'd0);
        chk("async_rst_valid", {63'd0, bus.deq_valid}, 64'd0);
        step();
        step();
        rst = 1'b0;
        drive(1'b1, 32'h400, 32'hE0);
        step();
        drive(1'b0, 32'd0, 32'd0);
        #2;
        chk("after_rst_count", {61'd0, count}, 64'd1);
        chk("after_rst_pc", {32'd0, bus.deq_pc}, 64'h400);
        step();
        bus.deq_ready = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction fetch queue that decouples icache responses from the IF/ID register.
- The IF stage stops stalling whenever the decode stage stalls for forwarding; stalls now come only from queue full.
- Each entry holds the PC, the 32-bit instruction and the branch-predictor metadata (pbp payload).
- A flush from branch/jump redirect empties the queue in one cycle. An optional bypass path gives zero-latency pass-through when the queue is empty.

Parameters:
DEPTH, 4, number of entries; power of 2, >= 2
XLEN, 32, PC width
META_W, 34, width of predictor metadata carried per entry (bp_br_en, y_out, bp_target)
BYPASS, 1, 1 = empty-queue enqueue visible on deq same cycle; 0 = minimum 1-cycle latency
AFULL_THRESH, DEPTH-1, count at or above which almost_full asserts

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
flush  input  1  redirect: discard all entries
enq_valid  input  1  icache response valid (icache_resp qualified by fetch logic)
enq_ready  output  1  entry can be accepted this cycle
enq_pc  input  XLEN  PC of fetched instruction
enq_instr  input  32  fetched instruction word
enq_meta  input  META_W  predictor metadata for this fetch
deq_valid  output  1  head entry valid
deq_ready  input  1  ID stage accepts head (ifid_load)
deq_pc  output  XLEN  head PC
deq_instr  output  32  head instruction
deq_meta  output  META_W  head metadata
count  output  $clog2(DEPTH+1)  current occupancy
almost_full  output  1  count >= AFULL_THRESH
full_stall_cycles  output  32  perf counter: cycles with enq_valid && !enq_ready

Behaviour:
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an explicit count register. Full is count==DEPTH; empty is count==0.
- Reset (async, rst=1): head=tail=0, count=0, full_stall_cycles=0. deq_valid=0 and almost_full=0 (if AFULL_THRESH>0). enq_ready=1. Entry contents are don't-care.
- enq_ready = !full. No enqueue into a full queue, even if deq_ready is high the same cycle.
- Enqueue fires when enq_valid && enq_ready && !flush. The entry is written at tail, tail increments.
- Dequeue fires when deq_valid && deq_ready && !flush. Head increments.
- Enqueue and dequeue in the same cycle with the queue non-empty: count is unchanged and both pointers advance.
- Outputs: deq_* are driven combinationally from the storage entry at head. deq_valid = !empty when not bypassing.
- BYPASS=1 and empty:
  - deq_valid = enq_valid && !flush, and deq_* = enq_*.
  - If deq_ready, the entry is consumed directly: no write, pointers and count unchanged.
  - If !deq_ready, the entry is written normally.
- BYPASS=0 and empty: deq_valid=0. An enqueued entry appears on deq the next cycle.
- Flush has highest priority:
  - On the clock edge with flush=1: head=tail=0 and count=0; any enq/deq that cycle is discarded.
  - During the flush cycle, deq_valid=0; enq_ready still reflects !full.
  - The cycle after flush, the queue is empty and accepts normally.
- full_stall_cycles increments on each edge where enq_valid && !enq_ready && !flush. It saturates at 2^32-1 and is cleared only by rst.
- almost_full is combinational from count.
- Reset asserted mid-operation: state clears immediately (async). The first enqueue is accepted on the first edge after deassertion.

Test Plan:
- Reset then idle -> count=0, deq_valid=0, enq_ready=1, full_stall_cycles=0.
- BYPASS=1, empty, enq_valid=1 pc=0x60 instr=0x00000013, deq_ready=1 -> same cycle deq_valid=1, deq_pc=0x60; next cycle count=0.
- DEPTH=4, deq_ready=0, enqueue pcs 0x0,0x4,0x8,0xC -> count=4, enq_ready=0, almost_full=1. Hold enq_valid 3 more cycles -> full_stall_cycles=3. Then dequeue 4 -> pcs in order 0x0..0xC and count=0.
- Wrap-around: enqueue 6 and dequeue interleaved 1-for-1 from count=2 -> FIFO order preserved across pointer wrap; count stays 2.
- Queue holding 3 entries, flush=1 with enq_valid=1 and deq_ready=1 -> deq_valid=0 during flush; next cycle count=0; the flush-cycle enqueue is not stored.
- rst pulsed mid-stream with count=2 -> count=0 and deq_valid=0 immediately, without waiting for a clock edge.
